// File: rtl/cp0_ex_ctrl.sv
// Exception/interrupt/ERET sequencer in front of CP0: one COMMIT cycle of CP0
// writes, a fixed-length pipeline flush, then a valid/ready redirect to fetch.
module cp0_ex_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EX_ENTRY     = 32'hbfc00380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic        ws_ex,
  input  logic [4:0]  ws_excode,
  input  logic        ws_eret,
  input  logic        ws_bd,
  input  logic [31:0] ws_pc,
  input  logic        int_pending,
  input  logic [31:0] cp0_epc,
  output logic [2:0]  cp0_ex_code,
  output logic [4:0]  cp0_excode,
  output logic [31:0] cp0_wdata,
  output logic        cp0_bd,
  output logic        cp0_eret,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_FLUSH, S_REDIRECT} state_e;
  typedef enum logic [1:0] {K_NONE, K_INT, K_EXC, K_ERET} kind_e;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [31:0] pc_q, pc_d;
  logic        bd_q, bd_d;
  logic [4:0]  excode_q, excode_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        holdoff_q, holdoff_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d        = state_q;
    kind_d         = kind_q;
    pc_d           = pc_q;
    bd_d           = bd_q;
    excode_d       = excode_q;
    cnt_d          = cnt_q;
    holdoff_d      = holdoff_q;
    redirect_pc_d  = redirect_pc_q;
    cp0_ex_code    = 3'b000;
    cp0_excode     = 5'h00;
    cp0_wdata      = 32'h0;
    cp0_bd         = 1'b0;
    cp0_eret       = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    case (state_q)
      S_IDLE: begin
        // Holdoff lasts a single IDLE cycle so CP0's EXL clear can reach int_pending.
        holdoff_d = 1'b0;
        if (ws_valid) begin
          pc_d = ws_pc;
          bd_d = ws_bd;
          if (int_pending && !holdoff_q) begin
            kind_d   = K_INT;
            excode_d = 5'h00;
            state_d  = S_COMMIT;
          end else if (ws_ex) begin
            kind_d   = K_EXC;
            excode_d = ws_excode;
            state_d  = S_COMMIT;
          end else if (ws_eret) begin
            kind_d   = K_ERET;
            excode_d = 5'h00;
            state_d  = S_COMMIT;
          end
        end
      end

      S_COMMIT: begin
        flush = 1'b0 | 1'b1;
        if (kind_q == K_INT || kind_q == K_EXC) begin
          cp0_ex_code = (kind_q == K_INT) ? 3'b010 : 3'b001;
          cp0_excode  = excode_q;
          cp0_wdata   = pc_q;
          cp0_bd      = bd_q;
        end
        cp0_eret = (kind_q == K_ERET);
        // EPC is read before CP0 applies this cycle's write, so a new EPC is never used.
        redirect_pc_d = (kind_q == K_ERET) ? cp0_epc : EX_ENTRY;
        cnt_d         = FLUSH_INIT;
        state_d       = S_FLUSH;
      end

      S_FLUSH: begin
        flush = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = redirect_pc_q;
        if (redirect_ready) begin
          holdoff_d = (kind_q == K_ERET);
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
    if (reset) begin
      state_q       <= S_IDLE;
      kind_q        <= K_NONE;
      pc_q          <= 32'h0;
      bd_q          <= 1'b0;
      excode_q      <= 5'h00;
      cnt_q         <= 4'd0;
      holdoff_q     <= 1'b0;
      redirect_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      pc_q          <= pc_d;
      bd_q          <= bd_d;
      excode_q      <= excode_d;
      cnt_q         <= cnt_d;
      holdoff_q     <= holdoff_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

endmodule
